// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
//
// Single-clock FIFO with an arbitrary depth (>= 2, not limited to powers of
// two), a selectable read mode, run-time almost-full/almost-empty thresholds,
// an occupancy count and a synchronous flush.
//
// Parameters
//   DATA_WIDTH  width of data_in / data_out
//   DEPTH       number of entries (>= 2)
//   FWFT        0 = standard read (data_out registered, valid the cycle after
//               an accepted read); 1 = first-word-fall-through (head word
//               shown combinationally whenever the FIFO is not empty)
//   CW          derived width of count and the threshold inputs
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   wr_en, data_in    write request and data
//   rd_en             read request (pops the head in FWFT mode)
//   flush             synchronous clear; overrides wr_en / rd_en that cycle
//   af_level          almostfull  = count >= af_level
//   ae_level          almostempty = count <= ae_level
//   data_out          read data
//   full, empty       count == DEPTH / count == 0
//   count             current occupancy
//   wr_ack            previous cycle's write was accepted
//   overflow          previous cycle's write was rejected because full
//   underflow         previous cycle's read was rejected because empty
// ---------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int  DATA_WIDTH = 16,
  parameter int  DEPTH      = 8,
  parameter int  FWFT       = 0,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CW-1:0]         af_level,
  input  logic [CW-1:0]         ae_level,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int            PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_r;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_ack_r;
  logic                  overflow_r;
  logic                  underflow_r;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Status is derived from the registered count only; thresholds are live
  // inputs and act without a clock. An af_level above DEPTH can never be
  // reached, so almostfull then stays low.
  assign full        = (count_r == DEPTH_CNT);
  assign empty       = (count_r == '0);
  assign almostfull  = (count_r >= af_level);
  assign almostempty = (count_r <= ae_level);
  assign count       = count_r;

  assign wr_ack      = wr_ack_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

  // A flush swallows both requests of its cycle. When full, a simultaneous
  // read is still accepted but the write is not (and vice versa when empty),
  // because acceptance looks at the state before this edge.
  assign wr_acc = wr_en & ~full  & ~flush;
  assign rd_acc = rd_en & ~empty & ~flush;

  // Control state: pointers, occupancy and handshake pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      wr_ack_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      wr_ack_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      wr_ack_r    <= wr_acc;
      overflow_r  <= wr_en & full;
      underflow_r <= rd_en & empty;
    end
  end

  // Storage array; contents survive reset and flush, only pointers move.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible with zero latency; forced to zero while empty so
      // the output is defined during and after reset.
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_r;

      // Registered read port: updates only on an accepted read and holds
      // through rejected reads and flushes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r <= '0;
        end else if (rd_acc) begin
          dout_r <= mem[rd_ptr];
        end
      end

      assign data_out = dout_r;
    end
  endgenerate

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's fixed FIFO block.
- Adds non-power-of-two depth, selectable standard or first-word-fall-through (FWFT) read mode, run-time almost-full/almost-empty thresholds, an occupancy count output, and a synchronous flush.
- Sits between producer and consumer stages in the same clock domain.
- Keeps the existing status set: full, empty, almost flags, wr_ack, overflow, underflow.

Parameters:
- DATA_WIDTH, 16, width of data_in/data_out.
- DEPTH, 8, number of entries; any value >= 2, need not be a power of two.
- FWFT, 0, read mode: 0 = standard (registered read, 1-cycle latency), 1 = first-word-fall-through.
- CW (derived, not overridable), $clog2(DEPTH+1), width of count and thresholds.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- flush  in  1  synchronous clear of contents.
- data_in  in  DATA_WIDTH  write data.
- af_level  in  CW  almost-full threshold.
- ae_level  in  CW  almost-empty threshold.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almostfull  out  1  count >= af_level.
- almostempty  out  1  count <= ae_level.
- count  out  CW  current occupancy.
- wr_ack  out  1  registered: previous cycle's write was accepted.
- overflow  out  1  registered: previous cycle's write was rejected (full).
- underflow  out  1  registered: previous cycle's read was rejected (empty).

Behaviour:
- Reset (rst_n=0, async):
  - wr_ptr, rd_ptr, count = 0; data_out = 0; wr_ack, overflow, underflow = 0.
  - Status outputs follow: empty=1, full=0, almostempty=1, almostfull=(af_level==0).
  - Memory contents are not reset.
- Accept rules, evaluated on the registered state at the rising edge:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
- Pointer and count updates:
  - Accepted write stores at mem[wr_ptr]; wr_ptr advances, wrapping DEPTH-1 -> 0.
  - Accepted read advances rd_ptr with the same wrap.
  - count next = count + wr_acc - rd_acc; simultaneous accepted read and write leave count unchanged.
- Full and empty corner cases:
  - When full, rd_en & wr_en: only the read is accepted; overflow=1 next cycle; count becomes DEPTH-1.
  - When empty, rd_en & wr_en: only the write is accepted; underflow=1 next cycle.
  - In FWFT mode the written word appears on data_out the following cycle.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr], visible the cycle after the request.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] whenever empty=0, with zero latency.
  - rd_en pops the head; data_out is don't-care while empty.
  - The bench must only check data_out when empty=0.
- Status outputs (full, empty, almostfull, almostempty, count):
  - Combinational from registered count and the threshold inputs.
  - Thresholds may change at any time and take effect immediately.
  - af_level > DEPTH means almostfull is never asserted.
- Handshake outputs:
  - wr_ack, overflow, underflow are single-cycle pulses, registered one cycle after the request edge.
  - They are mutually independent; wr_ack and underflow may assert in the same cycle.
- flush=1 at a rising edge:
  - Pointers and count go to 0; wr_en and rd_en in that cycle are ignored.
  - wr_ack, overflow, underflow are 0 the next cycle.
  - data_out is unchanged in standard mode.
- Reset asserted mid-transfer aborts it immediately; no partial pointer update survives.

Test Plan:
- Fill/drain (DATA_WIDTH=16, DEPTH=8, FWFT=0): write 0x0001..0x0008 on consecutive cycles -> wr_ack each following cycle; full=1 and count=8 after the 8th. Read 8 times -> data_out 0x0001..0x0008, each one cycle after rd_en; empty=1 at the end.
- Overflow/underflow: with count=8, wr_en=1 for one cycle -> overflow pulses once, count stays 8. With count=0, rd_en=1 -> underflow pulses, data_out unchanged.
- Simultaneous access at boundaries:
  - count=8, rd_en=wr_en=1 -> count=7, overflow=1, data_out = oldest word.
  - count=0, rd_en=wr_en=1 -> count=1, underflow=1, wr_ack=1.
  - count=4, rd_en=wr_en=1 -> count stays 4.
- Non-power-of-two wrap: DEPTH=5, 13 interleaved writes and reads with wrap-around -> output order matches input order; count never exceeds 5.
- FWFT: FWFT=1, write 0xBEEF into an empty FIFO -> data_out=0xBEEF and empty=0 the next cycle with no rd_en. Pop -> empty=1.
- Thresholds, flush and reset:
  - af_level=6, ae_level=2: almostfull asserts at count=6; almostempty deasserts at count=3.
  - flush with count=5 -> count=0, empty=1 next cycle.
  - rst_n low mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
